// File: rtl/pipe_pkg.sv
// ----------------------------------------------------------------------------
// pipe_pkg
// Shared types and constants for the pipe_reg pipeline register.
//   pipe_state_e   : occupancy state of the two-entry register (EMPTY/ONE/FULL)
//   PIPE_MAX_WIDTH : largest supported payload width
//   state_count()  : maps a state to its occupancy count (0, 1 or 2)
// ----------------------------------------------------------------------------
package pipe_pkg;

    localparam int unsigned PIPE_MAX_WIDTH = 256;

    typedef enum logic [1:0] {
        PS_EMPTY = 2'b00,
        PS_ONE   = 2'b01,
        PS_FULL  = 2'b10
    } pipe_state_e;

    function automatic logic [1:0] state_count(input pipe_state_e s);
        logic [1:0] c;
        case (s)
            PS_ONE:  c = 2'd1;
            PS_FULL: c = 2'd2;
            default: c = 2'd0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/pipe_reg_ctrl.sv
// ----------------------------------------------------------------------------
// pipe_reg_ctrl
// Occupancy FSM for pipe_reg. Tracks how many payloads are held (main + skid)
// and issues the write strobes for the datapath. Status outputs are flops
// loaded from the next state, so none of them depends combinationally on
// in_valid, out_ready or flush.
// Ports:
//   clk, reset      : clock, asynchronous active-low reset
//   flush           : synchronous flush, forces EMPTY
//   in_valid        : upstream offers a payload
//   out_ready       : downstream takes the payload this cycle
//   main_we         : load the main register this cycle
//   main_sel_skid   : main register loads from skid (else from in_data)
//   skid_we         : load the skid register this cycle
//   in_ready        : registered, state != FULL
//   out_valid       : registered, state != EMPTY
//   count           : registered occupancy 0/1/2
// ----------------------------------------------------------------------------
module pipe_reg_ctrl
    import pipe_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       flush,
    input  logic       in_valid,
    input  logic       out_ready,
    output logic       main_we,
    output logic       main_sel_skid,
    output logic       skid_we,
    output logic       in_ready,
    output logic       out_valid,
    output logic [1:0] count
);

    pipe_state_e state;
    pipe_state_e state_nxt;
    logic        accept;
    logic        pop;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_nxt     = state;
        main_we       = 1'b0;
        main_sel_skid = 1'b0;
        skid_we       = 1'b0;
        accept        = in_valid & in_ready;
        pop           = out_valid & out_ready;

        if (flush) begin
            // Flush wins over accept and pop; data registers are left alone.
            state_nxt = PS_EMPTY;
        end else begin
            case (state)
                PS_EMPTY: begin
                    if (accept) begin
                        state_nxt = PS_ONE;
                        main_we   = 1'b1;
                    end
                end
                PS_ONE: begin
                    if (accept && pop) begin
                        main_we = 1'b1;
                    end else if (accept) begin
                        state_nxt = PS_FULL;
                        skid_we   = 1'b1;
                    end else if (pop) begin
                        state_nxt = PS_EMPTY;
                    end
                end
                PS_FULL: begin
                    // in_ready is 0 here, so only a pop can occur.
                    if (pop) begin
                        state_nxt     = PS_ONE;
                        main_we       = 1'b1;
                        main_sel_skid = 1'b1;
                    end
                end
                default: state_nxt = PS_EMPTY;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= PS_EMPTY;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            count     <= 2'd0;
        end else begin
            state     <= state_nxt;
            in_ready  <= (state_nxt != PS_FULL);
            out_valid <= (state_nxt != PS_EMPTY);
            count     <= state_count(state_nxt);
        end
    end

endmodule

// File: rtl/pipe_reg.sv
// ----------------------------------------------------------------------------
// pipe_reg
// Pipeline register with valid/ready handshake, two-entry skid buffer and
// synchronous flush. Sustains one transfer per cycle under back-pressure;
// in_ready comes from a flop and never from out_ready.
// Optional feature (macro PIPE_REG_STALL_CNT_EN): saturating stall counter
// on port stall_cnt, counting cycles with out_valid=1 and out_ready=0.
// Ports:
//   clk        : rising-edge clock
//   reset      : asynchronous active-low reset
//   flush      : synchronous flush, active-high
//   in_data    : upstream payload (WIDTH)
//   in_valid   : upstream payload valid
//   in_ready   : block can accept this cycle
//   out_data   : downstream payload, the main register (WIDTH)
//   out_valid  : out_data is valid
//   out_ready  : downstream accepts this cycle
//   count      : occupancy 0/1/2
//   stall_cnt  : stall counter (STALL_CNT_W), only with PIPE_REG_STALL_CNT_EN
// ----------------------------------------------------------------------------
module pipe_reg
    import pipe_pkg::*;
#(
    parameter int unsigned      WIDTH       = 64,
    parameter logic [WIDTH-1:0] RESET_VAL   = '0,
    parameter int unsigned      STALL_CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       count
`ifdef PIPE_REG_STALL_CNT_EN
    ,
    output logic [STALL_CNT_W-1:0] stall_cnt
`endif
);

    if (WIDTH < 1 || WIDTH > PIPE_MAX_WIDTH || STALL_CNT_W < 1) begin : g_param_check
        $error("pipe_reg: WIDTH must be 1..%0d and STALL_CNT_W >= 1", PIPE_MAX_WIDTH);
    end

    logic             main_we;
    logic             main_sel_skid;
    logic             skid_we;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;

    pipe_reg_ctrl u_ctrl (
        .clk           (clk),
        .reset         (reset),
        .flush         (flush),
        .in_valid      (in_valid),
        .out_ready     (out_ready),
        .main_we       (main_we),
        .main_sel_skid (main_sel_skid),
        .skid_we       (skid_we),
        .in_ready      (in_ready),
        .out_valid     (out_valid),
        .count         (count)
    );

    // NOTE: the data registers are reset because out_data must show
    // RESET_VAL while and after reset is asserted; a plain storage array
    // without such a visible reset value would be left unreset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            main_q <= RESET_VAL;
            skid_q <= RESET_VAL;
        end else begin
            if (main_we) begin
                main_q <= main_sel_skid ? skid_q : in_data;
            end
            if (skid_we) begin
                skid_q <= in_data;
            end
        end
    end

    assign out_data = main_q;

`ifdef PIPE_REG_STALL_CNT_EN
    localparam logic [STALL_CNT_W-1:0] STALL_MAX = '1;

    // Saturating count of stalled cycles; flush clears it ahead of increment.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
        end else if (flush) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != STALL_MAX)) begin
            stall_cnt <= stall_cnt + STALL_CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_pipe_reg.sv
// ----------------------------------------------------------------------------
// tb_pipe_reg
// Directed, table-driven bench for pipe_reg (WIDTH=24, RESET_VAL=0,
// STALL_CNT_W=4). Inputs change 1 ns after the rising edge; outputs are
// compared 1 ns after the following rising edge.
// ----------------------------------------------------------------------------
module tb_pipe_reg;

    localparam int unsigned      WIDTH       = 24;
    localparam logic [WIDTH-1:0] RESET_VAL   = 24'h000000;
    localparam int unsigned      STALL_CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             flush;
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic [1:0]       count;
`ifdef PIPE_REG_STALL_CNT_EN
    logic [STALL_CNT_W-1:0] stall_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    pipe_reg #(
        .WIDTH       (WIDTH),
        .RESET_VAL   (RESET_VAL),
        .STALL_CNT_W (STALL_CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count)
`ifdef PIPE_REG_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic             in_valid;
        logic [WIDTH-1:0] in_data;
        logic             out_ready;
        logic             flush;
        logic             exp_valid;
        logic             exp_ready;
        logic [1:0]       exp_count;
        logic             chk_data;
        logic [WIDTH-1:0] exp_data;
    } vec_t;

    localparam int N_VEC = 17;
    vec_t vecs [N_VEC];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic iv, input logic [WIDTH-1:0] d, input logic ordy, input logic fl);
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
    endtask

    task automatic check_status(input string tag, input logic v, input logic r, input logic [1:0] c);
        check({tag, " out_valid"}, 64'(out_valid), 64'(v));
        check({tag, " in_ready"},  64'(in_ready),  64'(r));
        check({tag, " count"},     64'(count),     64'(c));
    endtask

    initial begin
        //                iv  in_data       ordy fl  v  r  cnt  chk  data
        // streaming, one transfer per cycle
        vecs[0]  = '{1'b1, 24'h0000FF, 1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 1'b1, 24'h0000FF};
        vecs[1]  = '{1'b1, 24'h00FF00, 1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 1'b1, 24'h00FF00};
        vecs[2]  = '{1'b1, 24'hFF0000, 1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 1'b1, 24'hFF0000};
        vecs[3]  = '{1'b0, 24'h000000, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 24'h000000};
        // back-pressure fills the skid; FULL refuses a third word
        vecs[4]  = '{1'b1, 24'hCACACA, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 1'b1, 24'hCACACA};
        vecs[5]  = '{1'b1, 24'h123456, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 1'b1, 24'hCACACA};
        vecs[6]  = '{1'b1, 24'h999999, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 1'b1, 24'hCACACA};
        vecs[7]  = '{1'b0, 24'h000000, 1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 1'b1, 24'h123456};
        vecs[8]  = '{1'b0, 24'h000000, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 24'h000000};
        // ONE with simultaneous accept and pop
        vecs[9]  = '{1'b1, 24'h000001, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 1'b1, 24'h000001};
        vecs[10] = '{1'b1, 24'h000002, 1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 1'b1, 24'h000002};
        vecs[11] = '{1'b0, 24'h000000, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 1'b1, 24'h000002};
        // flush from FULL drops the offered word and the held ones
        vecs[12] = '{1'b1, 24'h000003, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 1'b1, 24'h000002};
        vecs[13] = '{1'b1, 24'hABCDEF, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 24'h000000};
        vecs[14] = '{1'b0, 24'h000000, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 24'h000000};
        vecs[15] = '{1'b1, 24'h000004, 1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 1'b1, 24'h000004};
        vecs[16] = '{1'b0, 24'h000000, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 24'h000000};

        // Reset state
        reset = 1'b0;
        drive(1'b0, '0, 1'b0, 1'b0);
        tick();
        check_status("reset", 1'b0, 1'b1, 2'd0);
        check("reset out_data", 64'(out_data), 64'(RESET_VAL));
`ifdef PIPE_REG_STALL_CNT_EN
        check("reset stall_cnt", 64'(stall_cnt), 64'd0);
`endif
        tick();
        reset = 1'b1;
        tick();

        // Table-driven vectors
        for (int i = 0; i < N_VEC; i++) begin
            drive(vecs[i].in_valid, vecs[i].in_data, vecs[i].out_ready, vecs[i].flush);
            tick();
            check_status($sformatf("v%0d", i), vecs[i].exp_valid, vecs[i].exp_ready, vecs[i].exp_count);
            if (vecs[i].chk_data) begin
                check($sformatf("v%0d out_data", i), 64'(out_data), 64'(vecs[i].exp_data));
            end
        end

        // Asynchronous reset mid-run while FULL: takes effect without a clock edge
        drive(1'b1, 24'h111111, 1'b0, 1'b0);
        tick();
        drive(1'b1, 24'h222222, 1'b0, 1'b0);
        tick();
        drive(1'b0, '0, 1'b0, 1'b0);
        check_status("prefill", 1'b1, 1'b0, 2'd2);
        check("prefill out_data", 64'(out_data), 64'h111111);
        #2;
        reset = 1'b0;
        #1;
        check_status("async reset", 1'b0, 1'b1, 2'd0);
        check("async reset out_data", 64'(out_data), 64'(RESET_VAL));
`ifdef PIPE_REG_STALL_CNT_EN
        check("async reset stall_cnt", 64'(stall_cnt), 64'd0);
`endif
        tick();
        reset = 1'b1;
        // After release nothing of the discarded contents comes back
        drive(1'b0, '0, 1'b1, 1'b0);
        tick();
        check_status("post reset", 1'b0, 1'b1, 2'd0);
        drive(1'b1, 24'h333333, 1'b1, 1'b0);
        tick();
        check("post reset out_data", 64'(out_data), 64'h333333);
        drive(1'b0, '0, 1'b1, 1'b0);
        tick();
        check_status("post reset drain", 1'b0, 1'b1, 2'd0);

`ifdef PIPE_REG_STALL_CNT_EN
        // Stall counter: saturates at 15, flush clears it
        drive(1'b0, '0, 1'b0, 1'b1);
        tick();
        check("stall clear", 64'(stall_cnt), 64'd0);
        drive(1'b1, 24'h000005, 1'b0, 1'b0);
        tick();
        check("stall first", 64'(stall_cnt), 64'd0);
        drive(1'b0, '0, 1'b0, 1'b0);
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (c == 3) check("stall 3", 64'(stall_cnt), 64'd3);
            if (c == 15) check("stall 15", 64'(stall_cnt), 64'd15);
        end
        check("stall saturated", 64'(stall_cnt), 64'd15);
        check("stall out_valid", 64'(out_valid), 64'd1);
        drive(1'b0, '0, 1'b0, 1'b1);
        tick();
        check("stall flushed", 64'(stall_cnt), 64'd0);
        drive(1'b0, '0, 1'b0, 1'b0);
        tick();
        check("stall idle", 64'(stall_cnt), 64'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
